// File: rtl/cpu_pkg.sv
// cpu_pkg: shared core constants, widths and the fetch-stage state encoding.
package cpu_pkg;
  localparam int PC_WIDTH_DEF = 64;
  localparam int INSTR_W_DEF = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_SQUASH} fetch_state_t;
endpackage

// File: rtl/fetch_skid.sv
// fetch_skid: one-entry {pc,instr} holding buffer for a return that arrives while decode is stalled.
module fetch_skid #(
  parameter int PC_WIDTH = 64,
  parameter int INSTR_W = 32
) (
  input  logic                clk,
  input  logic                arst,
  input  logic                load,
  input  logic                drain,
  input  logic                clear,
  input  logic [PC_WIDTH-1:0] in_pc,
  input  logic [INSTR_W-1:0]  in_instr,
  output logic                full,
  output logic [PC_WIDTH-1:0] pc,
  output logic [INSTR_W-1:0]  instr
);
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      full <= 1'b0;
      pc <= '0;
      instr <= '0;
    end else if (clear || drain) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
      pc <= in_pc;
      instr <= in_instr;
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC generation, single-outstanding imem sequencing with wrong-path squash, and the IF/ID register.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int PC_WIDTH = PC_WIDTH_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                arst,
  input  logic                hazard,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_rvalid,
  input  logic [INSTR_W-1:0]  imem_rdata,
  output logic [PC_WIDTH-1:0] if_id_pc,
  output logic [INSTR_W-1:0]  if_id_instr,
  output logic                if_id_valid
);
  fetch_state_t state;
  logic [PC_WIDTH-1:0] pc, req_pc, skid_pc;
  logic [INSTR_W-1:0] skid_instr;
  logic skid_full, accept;
  assign accept = state == S_WAIT && imem_rvalid && !branch_taken;
  assign imem_req = !arst && state == S_FETCH && !skid_full && !branch_taken;
  assign imem_addr = pc;
  fetch_skid #(.PC_WIDTH(PC_WIDTH), .INSTR_W(INSTR_W)) u_skid (
    .clk(clk),
    .arst(arst),
    .load(accept && hazard),
    .drain(!hazard && skid_full),
    .clear(branch_taken),
    .in_pc(req_pc),
    .in_instr(imem_rdata),
    .full(skid_full),
    .pc(skid_pc),
    .instr(skid_instr)
  );
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state <= S_FETCH;
      pc <= RESET_PC;
      req_pc <= '0;
      if_id_pc <= '0;
      if_id_instr <= INSTR_W'(NOP_INSTR);
      if_id_valid <= 1'b0;
    end else begin
      if (imem_req) req_pc <= pc;
      if (branch_taken) begin
        // A redirect in S_WAIT without a return still owes one response, which must be dropped.
        pc <= branch_target;
        state <= state == S_WAIT ? (imem_rvalid ? S_FETCH : S_SQUASH) : state;
        if_id_instr <= INSTR_W'(NOP_INSTR);
        if_id_valid <= 1'b0;
      end else begin
        if (accept) pc <= req_pc + PC_WIDTH'(4);
        state <= state == S_FETCH ? (imem_req ? S_WAIT : S_FETCH) : (imem_rvalid ? S_FETCH : state);
        if (!hazard) begin
          if_id_valid <= skid_full || accept;
          if_id_instr <= skid_full ? skid_instr : accept ? imem_rdata : INSTR_W'(NOP_INSTR);
          if (skid_full || accept) if_id_pc <= skid_full ? skid_pc : req_pc;
        end
      end
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vector table plus a hand-written async reset sequence for fetch_stage.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [63:0] WRAP = 64'hFFFF_FFFF_FFFF_FFFC;
  logic clk = 1'b0;
  logic arst = 1'b1;
  logic hazard = 1'b0, branch_taken = 1'b0, imem_rvalid = 1'b0;
  logic [63:0] branch_target = '0;
  logic [31:0] imem_rdata = '0;
  logic imem_req, if_id_valid;
  logic [63:0] imem_addr, if_id_pc;
  logic [31:0] if_id_instr;
  int checks = 0, failures = 0;
  typedef struct {
    logic hz, br;
    logic [63:0] tgt;
    logic rv;
    logic [31:0] rd;
    logic req;
    logic [63:0] addr;
    logic v;
    logic [63:0] ipc;
    logic [31:0] ins;
  } vec_t;
  vec_t vt[26];

  fetch_stage dut (
    .clk(clk), .arst(arst), .hazard(hazard), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .if_id_pc(if_id_pc),
    .if_id_instr(if_id_instr), .if_id_valid(if_id_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  initial begin
    // Columns: hazard, branch, target, rvalid, rdata | req, addr, valid, if_id_pc, if_id_instr
    vt[0]  = '{0, 0, 64'h0,   0, 32'h0,        1, 64'h0,   0, 64'h0,   NOP};
    vt[1]  = '{0, 0, 64'h0,   1, 32'h11111111, 0, 64'h0,   0, 64'h0,   NOP};
    vt[2]  = '{0, 0, 64'h0,   0, 32'h0,        1, 64'h4,   1, 64'h0,   32'h11111111};
    vt[3]  = '{0, 0, 64'h0,   1, 32'h22222222, 0, 64'h4,   0, 64'h0,   NOP};
    vt[4]  = '{0, 0, 64'h0,   0, 32'h0,        1, 64'h8,   1, 64'h4,   32'h22222222};
    vt[5]  = '{1, 0, 64'h0,   1, 32'h00A00093, 0, 64'h8,   0, 64'h4,   NOP};
    vt[6]  = '{1, 0, 64'h0,   0, 32'h0,        0, 64'hC,   0, 64'h4,   NOP};
    vt[7]  = '{0, 0, 64'h0,   0, 32'h0,        0, 64'hC,   0, 64'h4,   NOP};
    vt[8]  = '{0, 0, 64'h0,   0, 32'h0,        1, 64'hC,   1, 64'h8,   32'h00A00093};
    vt[9]  = '{0, 1, 64'h100, 0, 32'h0,        0, 64'hC,   0, 64'h8,   NOP};
    vt[10] = '{0, 0, 64'h0,   0, 32'h0,        0, 64'h100, 0, 64'h8,   NOP};
    vt[11] = '{0, 0, 64'h0,   0, 32'h0,        0, 64'h100, 0, 64'h8,   NOP};
    vt[12] = '{0, 0, 64'h0,   1, 32'hDEADBEEF, 0, 64'h100, 0, 64'h8,   NOP};
    vt[13] = '{0, 0, 64'h0,   0, 32'h0,        1, 64'h100, 0, 64'h8,   NOP};
    vt[14] = '{0, 0, 64'h0,   1, 32'h33333333, 0, 64'h100, 0, 64'h8,   NOP};
    vt[15] = '{0, 0, 64'h0,   0, 32'h0,        1, 64'h104, 1, 64'h100, 32'h33333333};
    vt[16] = '{1, 1, 64'h200, 1, 32'hBADBAD00, 0, 64'h104, 0, 64'h100, NOP};
    vt[17] = '{0, 0, 64'h0,   0, 32'h0,        1, 64'h200, 0, 64'h100, NOP};
    vt[18] = '{0, 0, 64'h0,   1, 32'h44444444, 0, 64'h200, 0, 64'h100, NOP};
    vt[19] = '{0, 0, 64'h0,   0, 32'h0,        1, 64'h204, 1, 64'h200, 32'h44444444};
    vt[20] = '{0, 0, 64'h0,   0, 32'h0,        0, 64'h204, 0, 64'h200, NOP};
    vt[21] = '{0, 1, WRAP,    0, 32'h0,        0, 64'h204, 0, 64'h200, NOP};
    vt[22] = '{0, 0, 64'h0,   1, 32'h0,        0, WRAP,    0, 64'h200, NOP};
    vt[23] = '{0, 0, 64'h0,   0, 32'h0,        1, WRAP,    0, 64'h200, NOP};
    vt[24] = '{0, 0, 64'h0,   1, 32'h55555555, 0, WRAP,    0, 64'h200, NOP};
    vt[25] = '{0, 0, 64'h0,   0, 32'h0,        1, 64'h0,   1, WRAP,    32'h55555555};

    // Reset held across clock edges, then released and a fetch launched.
    repeat (2) @(negedge clk);
    #1;
    chk("rst.req", 64'(imem_req), 64'h0);
    chk("rst.valid", 64'(if_id_valid), 64'h0);
    chk("rst.instr", 64'(if_id_instr), 64'(NOP));
    chk("rst.pc", if_id_pc, 64'h0);
    @(negedge clk);
    arst = 1'b0;
    #1;
    chk("rel.req", 64'(imem_req), 64'h1);
    chk("rel.addr", imem_addr, 64'h0);
    @(negedge clk);
    #1;
    chk("wait.req", 64'(imem_req), 64'h0);
    // Asynchronous reset in the middle of S_WAIT.
    #2 arst = 1'b1;
    #1;
    chk("arst.req", 64'(imem_req), 64'h0);
    chk("arst.valid", 64'(if_id_valid), 64'h0);
    chk("arst.instr", 64'(if_id_instr), 64'(NOP));
    @(negedge clk);
    arst = 1'b0;

    foreach (vt[i]) begin
      hazard = vt[i].hz;
      branch_taken = vt[i].br;
      branch_target = vt[i].tgt;
      imem_rvalid = vt[i].rv;
      imem_rdata = vt[i].rd;
      #1;
      chk($sformatf("v%0d.req", i), 64'(imem_req), 64'(vt[i].req));
      chk($sformatf("v%0d.addr", i), imem_addr, vt[i].addr);
      chk($sformatf("v%0d.valid", i), 64'(if_id_valid), 64'(vt[i].v));
      chk($sformatf("v%0d.pc", i), if_id_pc, vt[i].ipc);
      chk($sformatf("v%0d.instr", i), 64'(if_id_instr), 64'(vt[i].ins));
      @(negedge clk);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
